mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 opcode  input  6  instr[31:26] from instruction register, sampled in DECODE.
REQ-004 zero  input  1  ALU zero flag, valid in BRANCH/BNE states.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-006 pcen  output  1  PC write enable = pcwrite | (branch & zero) | (branchne & ~zero).
REQ-007 iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath controls.
REQ-008 alusrcb  output  2  00 reg B, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-009 pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 aluop  output  2  00 add, 01 sub, 10 funct-decoded (same encoding as the single-cycle decoder).
REQ-011 state  output  4  current state code, for debug.
REQ-012 illegal  output  1  one-cycle pulse on unsupported opcode.

Function
REQ-013 Moore FSM; all outputs SHALL be decoded from current state only, except pcen (REQ-006) and the mem_ready gating of REQ-016.
REQ-014 State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, BNE=12, TRAP=13; codes 14-15 SHALL go to FETCH.
REQ-015 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; holds while mem_ready=0; on mem_ready=1, irwrite=1 and pcwrite=1 in that cycle only, next DECODE.
REQ-016 In FETCH/MEMRD/MEMWR, irwrite, pcwrite and memwrite SHALL be gated by mem_ready, with no state change while mem_ready=0.
REQ-017 DECODE: alusrca=0, alusrcb=11, aluop=00; next by opcode: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->TRAP.
REQ-018 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD for LW, MEMWR for SW.
REQ-019 MEMRD: iord=1; on mem_ready next MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-020 MEMWR: iord=1, memwrite=mem_ready; on mem_ready next FETCH.
REQ-021 EXECUTE: alusrca=1, alusrcb=00, aluop=10; next ALUWB (regdst=1, memtoreg=0, regwrite=1); next FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next ADDIWB (regdst=0, memtoreg=0, regwrite=1); next FETCH.
REQ-024 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-025 TRAP: illegal=1, no register/memory/PC write; next FETCH (instruction is a NOP, PC already incremented).
REQ-026 Unlisted outputs in any state SHALL be 0; no x values on any output.
REQ-027 Instruction latency: J/BEQ 3 cycles, R/ADDI/SW 4, LW 5, each plus mem_ready=0 wait cycles.

Reset
REQ-028 reset=1 SHALL force state=FETCH asynchronously; all outputs SHALL be 0 during reset, except the combinational FETCH decodes (alusrcb=01).
REQ-029 Reset mid-instruction SHALL abandon it; no regwrite/memwrite SHALL occur in the cycle reset deasserts.
REQ-030 The first fetch SHALL begin on the first rising edge after reset deasserts.

Configuration
REQ-031 Macro MC_CONTROLLER_BNE_EN defined: DECODE routes opcode 000101 to BNE (as BRANCH but branchne=1, branch=0), so the PC loads when zero=0.
REQ-032 Macro undefined: opcode 000101 goes to TRAP; branchne is tied 0; state 12 is unreachable and goes to FETCH.

Verification
REQ-033 LW with mem_ready=1: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-034 FETCH with mem_ready low 3 cycles: state stays 0, irwrite=pcwrite=0; on the 4th cycle both are 1 for one cycle.
REQ-035 BEQ with zero=1 -> pcen=1 in BRANCH; with zero=0 -> pcen=0; both return to FETCH.
REQ-036 opcode 111111 -> DECODE then TRAP, illegal=1 for exactly one cycle, no regwrite/memwrite.
REQ-037 reset asserted in MEMWR with mem_ready=0 -> state=0 immediately and memwrite=0.
REQ-038 With MC_CONTROLLER_BNE_EN: opcode 000101, zero=0 -> state 12, pcen=1. Without it: illegal=1.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore state decode plus PC-enable and memory-handshake gating.
// Optional BNE support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  state_t state_r;
  state_t next_s;
  logic   store_r;
  logic   mr_s;
  logic   pcwrite_s;
  logic   branch_s;
  logic   branchne_s;

  // Handshake is masked during reset so no write strobe can escape while held in FETCH.
  assign mr_s  = mem_ready & ~reset;
  assign state = state_r;
  assign pcen  = pcwrite_s | (branch_s & zero) | (branchne_s & ~zero);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_s;
    end
  end

  // Remember LW vs SW at decode so MEMADR does not depend on a later opcode value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      store_r <= (opcode == 6'b101011);
    end else begin
      store_r <= store_r;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next_s     = S_FETCH;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    aluop      = 2'b00;
    illegal    = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    branchne_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        alusrcb = 2'b01;
        if (mr_s) begin
          irwrite   = 1'b1;
          pcwrite_s = 1'b1;
          next_s    = S_DECODE;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          6'b100011: next_s = S_MEMADR;
          6'b101011: next_s = S_MEMADR;
          6'b000000: next_s = S_EXECUTE;
          6'b000100: next_s = S_BRANCH;
          6'b001000: next_s = S_ADDIEX;
          6'b000010: next_s = S_JUMP;
`ifdef MC_CONTROLLER_BNE_EN
          6'b000101: next_s = S_BNE;
`endif
          default:   next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (store_r) begin
          next_s = S_MEMWR;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mr_s) begin
          next_s = S_MEMWB;
        end else begin
          next_s = S_MEMRD;
        end
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = mr_s;
        if (mr_s) begin
          next_s = S_FETCH;
        end else begin
          next_s = S_MEMWR;
        end
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        next_s  = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
        next_s   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        next_s  = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        next_s   = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
        next_s    = S_FETCH;
      end
`ifdef MC_CONTROLLER_BNE_EN
      S_BNE: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branchne_s = 1'b1;
        next_s     = S_FETCH;
      end
`endif
      S_TRAP: begin
        illegal = 1'b1;
        next_s  = S_FETCH;
      end
      default: begin
        next_s = S_FETCH;
      end
    endcase
  end

endmodule
